// File: rtl/decode_issue_queue_pkg.sv
// ---------------------------------------------------------------------------
// decode_issue_queue_pkg
// Shared types for the decode-to-execute issue queue:
//   RegAddr              - architectural register index (x0..x31)
//   RdCtrl               - destination write control carried with an entry
//   ExecuteStagePipeReg  - payload that decode hands to execute
//   DecodeQueueEntry     - queue slot: pipe register plus the store flag
//   DECODE_QUEUE_DEPTH_DEFAULT - default queue depth
// ---------------------------------------------------------------------------
package decode_issue_queue_pkg;

    localparam int DECODE_QUEUE_DEPTH_DEFAULT = 4;

    typedef logic [4:0] RegAddr;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLL   = 4'd6,
        ALU_SRL   = 4'd7,
        ALU_LOAD  = 4'd8,
        ALU_STORE = 4'd9
    } AluOp;

    typedef struct packed {
        logic   wEnable;
        RegAddr rdAddr;
    } RdCtrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] operandA;
        logic [31:0] operandB;
        AluOp        aluOp;
        RdCtrl       rdCtrl;
    } ExecuteStagePipeReg;

    typedef struct packed {
        ExecuteStagePipeReg pipeReg;
        logic               isStore;
    } DecodeQueueEntry;

    // x0 is hard-wired to zero, so it can never be a true RAW hazard.
    function automatic logic isRegX0(input RegAddr addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/decode_issue_queue_scoreboard.sv
// ---------------------------------------------------------------------------
// decode_queue_scoreboard
// Purely combinational RAW check of two decode source registers against the
// destinations of all occupied queue slots.
//   slotValid    in  per-slot occupancy mask
//   rdCtrl       in  per-slot destination control
//   queryRs1Addr in  source register 1 of the instruction in decode
//   queryRs2Addr in  source register 2 of the instruction in decode
//   rs1Busy      out an occupied slot writes queryRs1Addr (never for x0)
//   rs2Busy      out an occupied slot writes queryRs2Addr (never for x0)
// ---------------------------------------------------------------------------
module decode_queue_scoreboard
    import decode_issue_queue_pkg::*;
#(
    parameter int DEPTH = DECODE_QUEUE_DEPTH_DEFAULT
) (
    input  logic [DEPTH-1:0] slotValid,
    input  RdCtrl            rdCtrl [DEPTH],
    input  RegAddr           queryRs1Addr,
    input  RegAddr           queryRs2Addr,
    output logic             rs1Busy,
    output logic             rs2Busy
);

    always_comb begin
        rs1Busy = 1'b0;
        rs2Busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slotValid[i] && rdCtrl[i].wEnable && (rdCtrl[i].rdAddr == queryRs1Addr))
                rs1Busy = 1'b1;
            if (slotValid[i] && rdCtrl[i].wEnable && (rdCtrl[i].rdAddr == queryRs2Addr))
                rs2Busy = 1'b1;
        end
        if (isRegX0(queryRs1Addr)) rs1Busy = 1'b0;
        if (isRegX0(queryRs2Addr)) rs2Busy = 1'b0;
    end

endmodule

// File: rtl/decode_issue_queue.sv
// ---------------------------------------------------------------------------
// decode_issue_queue
// DEPTH-entry in-order FIFO between decode and execute, replacing the single
// decode/execute pipeline register. Valid/ready on both sides, single-cycle
// flush, RAW scoreboard over queued destinations and a pending-store count.
//
// Optional feature: define DECODE_QUEUE_BYPASS_EN to let an entry pass
// combinationally from input to output when the queue is empty and execute
// is ready (zero-cycle latency; nothing is written in that case).
//
// Ports:
//   clk          in  clock, rising edge
//   rst          in  asynchronous active-low reset
//   inValid      in  decode presents an entry
//   inReady      out queue accepts an entry this cycle
//   inEntry      in  decoded entry
//   inIsStore    in  entry is a store
//   outValid     out head entry valid
//   outReady     in  execute consumes the head
//   outEntry     out head entry
//   outIsStore   out head entry is a store
//   flush        in  discard all queued entries
//   queryRs1Addr in  decode source register 1
//   queryRs2Addr in  decode source register 2
//   rs1Busy      out a queued entry writes queryRs1Addr
//   rs2Busy      out a queued entry writes queryRs2Addr
//   count        out occupancy
//   storeCount   out queued stores
// ---------------------------------------------------------------------------
module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter  int DEPTH = DECODE_QUEUE_DEPTH_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inValid,
    output logic               inReady,
    input  ExecuteStagePipeReg inEntry,
    input  logic               inIsStore,
    output logic               outValid,
    input  logic               outReady,
    output ExecuteStagePipeReg outEntry,
    output logic               outIsStore,
    input  logic               flush,
    input  RegAddr             queryRs1Addr,
    input  RegAddr             queryRs2Addr,
    output logic               rs1Busy,
    output logic               rs2Busy,
    output logic [CNT_W-1:0]   count,
    output logic [CNT_W-1:0]   storeCount
);

    localparam int PTR_W = $clog2(DEPTH);

    DecodeQueueEntry  storage [DEPTH];
    logic [PTR_W-1:0] headPtr;
    logic [PTR_W-1:0] tailPtr;
    logic             doEnq;
    logic             doDeq;
    logic             bypassTake;
    logic             queueEmpty;
    logic             queueFull;
    logic [DEPTH-1:0] slotValid;
    RdCtrl            slotRdCtrl [DEPTH];

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign queueEmpty = (count == '0);
    assign queueFull  = (count == CNT_W'(DEPTH));

    // inReady deliberately ignores outReady: a full queue refuses input
    // even in a cycle where the head drains.
    assign inReady = !flush && !queueFull;

`ifdef DECODE_QUEUE_BYPASS_EN
    assign bypassTake = queueEmpty && inValid && outReady && !flush;
    assign outValid   = !flush && (!queueEmpty || bypassTake);
    assign outEntry   = bypassTake ? inEntry   : storage[headPtr].pipeReg;
    assign outIsStore = bypassTake ? inIsStore : storage[headPtr].isStore;
`else
    assign bypassTake = 1'b0;
    assign outValid   = !flush && !queueEmpty;
    assign outEntry   = storage[headPtr].pipeReg;
    assign outIsStore = storage[headPtr].isStore;
`endif

    // A bypassed entry is consumed directly and never touches the storage.
    assign doEnq = inValid && inReady && !bypassTake;
    assign doDeq = outValid && outReady && !bypassTake;

    // Slot i is occupied when its distance from head (mod DEPTH) is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : gSlot
        assign slotValid[i] =
            (((i >= int'(headPtr)) ? (i - int'(headPtr)) : (i + DEPTH - int'(headPtr)))
             < int'(count));
        assign slotRdCtrl[i] = storage[i].pipeReg.rdCtrl;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
            storeCount <= '0;
        end else if (flush) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
            storeCount <= '0;
        end else begin
            if (doEnq) tailPtr <= nextPtr(tailPtr);
            if (doDeq) headPtr <= nextPtr(headPtr);

            case ({doEnq, doDeq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case ({doEnq && inIsStore, doDeq && outIsStore})
                2'b10:   storeCount <= storeCount + 1'b1;
                2'b01:   storeCount <= storeCount - 1'b1;
                default: storeCount <= storeCount;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (doEnq) storage[tailPtr] <= '{pipeReg: inEntry, isStore: inIsStore};
    end

    decode_queue_scoreboard #(
        .DEPTH (DEPTH)
    ) uScoreboard (
        .slotValid    (slotValid),
        .rdCtrl       (slotRdCtrl),
        .queryRs1Addr (queryRs1Addr),
        .queryRs2Addr (queryRs2Addr),
        .rs1Busy      (rs1Busy),
        .rs2Busy      (rs2Busy)
    );

endmodule
